controle_mem_dados: RTL and testbench
=====================================

// Module: controle_mem_dados
// PURPOSE
//  Load/store unit downstream of the processor core. It consumes the ALU address (doutULA),
//  store data (dinDM), WeDM and funct3, and performs the access on a 64-bit data memory
//  with a variable-latency req/ack handshake. It returns the lane-aligned, sign/zero-extended
//  doutDM to the core. It stalls the core through 'ocupado' and flags misaligned, illegal
//  and timed-out accesses.
// PARAMETERS
//  TIMEOUT  255  max cycles waiting for mem_ack before abort (1..255, 8-bit counter)
// PORTS
//  clk       in   1   single clock, rising edge
//  reset     in   1   synchronous, active-high
//  WeDM      in   1   store request from core
//  ReDM      in   1   load request from core
//  funct3    in   3   access size/sign (RV64 load/store encoding)
//  doutULA   in   64  byte address
//  dinDM     in   64  store data, right-justified
//  doutDM    out  64  load result, extended; held until next load completes
//  ocupado   out  1   core must hold PC/pipeline while high
//  pronto    out  1   1-cycle pulse: access completed
//  erro      out  1   1-cycle pulse: misaligned/illegal/timeout, no memory update
//  mem_req   out  1   memory request, held until ack
//  mem_we    out  1   1=write
//  mem_addr  out  64  doubleword-aligned address {doutULA[63:3],3'b0}
//  mem_be    out  8   byte enables
//  mem_wdata out  64  store data shifted into lane (dinDM << 8*addr[2:0])
//  mem_rdata in   64  read data, valid in the mem_ack cycle
//  mem_ack   in   1   memory completion, 1 cycle
// BEHAVIOUR
//  - Reset: state OCIOSO; every output 0 (doutDM=0); timeout counter 0. A reset asserted
//    mid-access drops mem_req at the next edge. No pronto or erro is produced.
//  - FSM OCIOSO -> ACESSO -> CONCLUI -> OCIOSO. Requests are sampled only in OCIOSO.
//  - OCIOSO, at an edge with WeDM|ReDM:
//      * WeDM&ReDM both high, load funct3=111, or store funct3[2]=1: illegal.
//      * addr[k-1:0]!=0 for size 2^k: misaligned.
//      * Either case: erro pulses the next cycle, state stays OCIOSO, no mem_req.
//      * Otherwise: latch we/addr/be/wdata/funct3 and go to ACESSO.
//  - ocupado: combinational. High in OCIOSO when a legal request is present, and high
//    throughout ACESSO. Low in CONCLUI and in the erro cycle.
//  - ACESSO: mem_req=1 with latched fields stable until mem_ack. The ack edge captures
//    rdata and goes to CONCLUI. If the counter reaches TIMEOUT without ack: mem_req drops,
//    erro pulses, state returns to OCIOSO, doutDM is unchanged.
//  - CONCLUI: pronto=1 for one cycle. A load updates doutDM on entry to CONCLUI.
//  - Latency: request at edge N; mem_req high N+1..ack; pronto in the cycle after the
//    ack edge. Minimum 3 cycles (ack in first ACESSO cycle).
//  - Byte enables:
//      * B:  1<<a
//      * H:  3<<a
//      * W:  0x0F<<a
//      * D:  0xFF
//    where a = addr[2:0].
//  - Load extraction: rdata >> 8*a, then truncate to size.
//      * LB/LH/LW (000/001/010): sign-extend.
//      * LBU/LHU/LWU (100/101/110): zero-extend.
//      * LD (011): raw.
//  - mem_ack outside ACESSO is ignored. A request held high during CONCLUI is re-sampled
//    in the following OCIOSO cycle; the core must deassert after pronto.
// STRUCTURE
//  - Shared package mem_dados_pkg:
//      * funct3 constants F3_B/H/W/D/BU/HU/WU
//      * state encoding OCIOSO/ACESSO/CONCLUI
//      * function tamanho_bytes(funct3)
//  - One combinational sub-module, alinhador_lsu: generates be/wdata lanes and
//    extracts/extends load data. The FSM, counter and registers stay in the top.
// TESTING
//  1. LD addr=0x10, rdata=0x1122334455667788, ack 2 cycles after req
//     -> mem_be=FF, doutDM=0x1122334455667788, single pronto pulse.
//  2. LB addr=0x13, rdata byte3=0x80 -> mem_be=0x08, doutDM=0xFFFFFFFFFFFFFF80.
//     Same access as LBU -> doutDM=0x80.
//  3. SH addr=0x22, dinDM=0xBEEF -> mem_addr=0x20, mem_be=0x0C, mem_wdata=0xBEEF0000,
//     mem_we=1, pronto after ack.
//  4. LW addr=0x06 -> erro pulse, no mem_req.
//     WeDM&ReDM together -> erro.
//     Load funct3=111 -> erro.
//  5. TIMEOUT=4, ack never arrives -> mem_req high exactly 4 cycles, then erro,
//     ocupado low, doutDM unchanged.
//  6. Reset asserted during ACESSO -> next cycle mem_req=0, ocupado=0, doutDM=0;
//     a late mem_ack is ignored.

Source files
------------

// File: rtl/mem_dados_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes, FSM
// state encoding and the access-size helper.
package mem_dados_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] ACESSO  = 2'd1;
    localparam logic [1:0] CONCLUI = 2'd2;

    function automatic logic [3:0] tamanho_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return 4'd1;
            F3_H, F3_HU: return 4'd2;
            F3_W, F3_WU: return 4'd4;
            default:     return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/alinhador_lsu.sv
// Lane alignment for the load/store unit: byte enables and shifted store data
// for writes, lane extraction plus sign/zero extension for reads.
module alinhador_lsu
    import mem_dados_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  offset,
    input  logic [63:0] din,
    input  logic [63:0] rdata,
    output logic [7:0]  be,
    output logic [63:0] wdata,
    output logic [63:0] load_data
);

    logic [63:0] deslocado;

    assign wdata     = din << {offset, 3'b000};
    assign deslocado = rdata >> {offset, 3'b000};

    always_comb begin
        case (funct3[1:0])
            2'b00:   be = 8'h01 << offset;
            2'b01:   be = 8'h03 << offset;
            2'b10:   be = 8'h0F << offset;
            default: be = 8'hFF;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{56{deslocado[7]}},  deslocado[7:0]};
            F3_H:    load_data = {{48{deslocado[15]}}, deslocado[15:0]};
            F3_W:    load_data = {{32{deslocado[31]}}, deslocado[31:0]};
            F3_BU:   load_data = {56'd0, deslocado[7:0]};
            F3_HU:   load_data = {48'd0, deslocado[15:0]};
            F3_WU:   load_data = {32'd0, deslocado[31:0]};
            default: load_data = deslocado;
        endcase
    end

endmodule

// File: rtl/controle_mem_dados.sv
// Load/store unit between the core and a 64-bit data memory with a
// variable-latency req/ack handshake, stall output and error reporting.
module controle_mem_dados
    import mem_dados_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WeDM,
    input  logic        ReDM,
    input  logic [2:0]  funct3,
    input  logic [63:0] doutULA,
    input  logic [63:0] dinDM,
    output logic [63:0] doutDM,
    output logic        ocupado,
    output logic        pronto,
    output logic        erro,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack
);

    logic [1:0]  estado;
    logic [7:0]  contador;
    logic        we_q;
    logic [63:0] addr_q;
    logic [63:0] din_q;
    logic [2:0]  f3_q;
    logic [3:0]  tam;
    logic        requisicao;
    logic        amostra;
    logic        ilegal;
    logic        desalinhado;
    logic        aceita;
    logic        em_acesso;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] dado_carga;

    assign requisicao  = WeDM | ReDM;
    assign tam         = tamanho_bytes(funct3);
    assign ilegal      = (WeDM & ReDM) | (ReDM & (funct3 == 3'b111)) | (WeDM & funct3[2]);
    assign desalinhado = |(doutULA[2:0] & 3'(tam - 4'd1));
    // No request is taken while the previous error is still being reported.
    assign amostra     = (estado == OCIOSO) && !erro && requisicao;
    assign aceita      = amostra && !ilegal && !desalinhado;
    assign em_acesso   = (estado == ACESSO);

    assign ocupado   = aceita | em_acesso;
    assign pronto    = (estado == CONCLUI);
    assign mem_req   = em_acesso;
    assign mem_we    = em_acesso & we_q;
    assign mem_addr  = em_acesso ? {addr_q[63:3], 3'b000} : 64'd0;
    assign mem_be    = em_acesso ? be : 8'd0;
    assign mem_wdata = em_acesso ? wdata : 64'd0;

    alinhador_lsu u_alinhador (
        .funct3    (f3_q),
        .offset    (addr_q[2:0]),
        .din       (din_q),
        .rdata     (mem_rdata),
        .be        (be),
        .wdata     (wdata),
        .load_data (dado_carga)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= OCIOSO;
            contador <= 8'd0;
            we_q     <= 1'b0;
            addr_q   <= 64'd0;
            din_q    <= 64'd0;
            f3_q     <= 3'd0;
            erro     <= 1'b0;
            doutDM   <= 64'd0;
        end else begin
            erro <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (aceita) begin
                        estado   <= ACESSO;
                        contador <= 8'd0;
                        we_q     <= WeDM;
                        addr_q   <= doutULA;
                        din_q    <= dinDM;
                        f3_q     <= funct3;
                    end else if (amostra) begin
                        erro <= 1'b1;
                    end
                end
                ACESSO: begin
                    // An ack in the last allowed cycle still wins over the timeout.
                    if (mem_ack) begin
                        estado <= CONCLUI;
                        if (!we_q) begin
                            doutDM <= dado_carga;
                        end
                    end else if (contador == 8'(TIMEOUT - 1)) begin
                        estado   <= OCIOSO;
                        contador <= 8'd0;
                        erro     <= 1'b1;
                    end else begin
                        contador <= contador + 8'd1;
                    end
                end
                CONCLUI: estado <= OCIOSO;
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_mem_dados.sv
// Scoreboard bench for controle_mem_dados: byte-array reference memory, a
// responding memory model and a monitor that checks every completion.
module tb_controle_mem_dados;

    localparam int TIMEOUT_TB = 4;

    logic        clk;
    logic        reset;
    logic        WeDM;
    logic        ReDM;
    logic [2:0]  funct3;
    logic [63:0] doutULA;
    logic [63:0] dinDM;
    logic [63:0] doutDM;
    logic        ocupado;
    logic        pronto;
    logic        erro;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    typedef struct {
        bit          is_err;
        logic [63:0] dout;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        bit          we;
        int          reqc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ref_mem [256];
    logic [7:0]  dev_mem [256];
    logic [63:0] last_dout;
    int          n_checks;
    int          n_fail;
    int          issued;
    int          done_cnt;
    int          ack_delay;
    bit          no_ack;
    bit          force_ack;

    controle_mem_dados #(.TIMEOUT(TIMEOUT_TB)) dut (
        .clk       (clk),
        .reset     (reset),
        .WeDM      (WeDM),
        .ReDM      (ReDM),
        .funct3    (funct3),
        .doutULA   (doutULA),
        .dinDM     (dinDM),
        .doutDM    (doutDM),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .erro      (erro),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Little-endian read of the access width, then extension by the funct3 rules.
    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [7:0] a);
        int          n;
        logic [63:0] v;
        n = 1 << f3[1:0];
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(int'(a) + i)];
        if (!f3[2] && n < 8 && v[8*n-1]) begin
            for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [7:0] model_be(input int n, input int off);
        logic [7:0] b;
        b = 8'd0;
        for (int i = 0; i < n; i++) b[off + i] = 1'b1;
        return b;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] d, input int off);
        logic [63:0] w;
        w = 64'd0;
        for (int j = 0; j < 8; j++) begin
            if (j >= off) w[8*j +: 8] = d[8*(j-off) +: 8];
        end
        return w;
    endfunction

    task automatic preset_dword(input logic [7:0] a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) begin
            ref_mem[8'(int'(a) + i)] = v[8*i +: 8];
            dev_mem[8'(int'(a) + i)] = v[8*i +: 8];
        end
    endtask

    task automatic apply_stimulus(input bit we, input bit re, input logic [2:0] f3,
                                  input logic [63:0] addr, input logic [63:0] din,
                                  input int delay, input bit noack);
        exp_t e;
        int   n;
        int   off;
        bit   illegal;
        bit   mis;
        bit   got;
        n       = 1 << f3[1:0];
        off     = int'(addr[2:0]);
        illegal = (we && re) || (re && f3 == 3'b111) || (we && f3[2]);
        mis     = (off % n) != 0;
        e.is_err = 1'b1;
        e.dout   = last_dout;
        e.addr   = 64'd0;
        e.be     = 8'd0;
        e.wdata  = 64'd0;
        e.we     = 1'b0;
        e.reqc   = 0;
        if (!(illegal || mis)) begin
            e.addr  = {addr[63:3], 3'b000};
            e.be    = model_be(n, off);
            e.wdata = model_wdata(din, off);
            e.we    = we;
            if (noack) begin
                e.reqc = TIMEOUT_TB;
            end else begin
                e.is_err = 1'b0;
                e.reqc   = delay + 1;
                if (re) begin
                    last_dout = model_load(f3, addr[7:0]);
                    e.dout    = last_dout;
                end else begin
                    for (int i = 0; i < n; i++) ref_mem[8'(int'(addr[7:0]) + i)] = din[8*i +: 8];
                end
            end
        end
        exp_q.push_back(e);
        issued++;
        ack_delay = delay;
        no_ack    = noack;
        WeDM    = we;
        ReDM    = re;
        funct3  = f3;
        doutULA = addr;
        dinDM   = din;
        #1;
        check_output("ocupado_on_request", 64'(ocupado), 64'(!(illegal || mis)));
        @(negedge clk);
        WeDM = 1'b0;
        ReDM = 1'b0;
        #2;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done_cnt == issued) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #2;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL completion_wait: got no pronto/erro expected one within 40 cycles");
            exp_q.delete();
            done_cnt = issued;
        end
        @(negedge clk);
    endtask

    // Memory side: acks after ack_delay cycles of mem_req and applies writes by byte enable.
    initial begin
        int wait_cnt;
        logic [63:0] dw;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 64'd0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
            end else if (mem_req && !reset) begin
                if (!no_ack && wait_cnt == ack_delay) begin
                    for (int i = 0; i < 8; i++) dw[8*i +: 8] = dev_mem[{mem_addr[7:3], 3'(i)}];
                    mem_rdata = dw;
                    mem_ack   = 1'b1;
                    if (mem_we) begin
                        for (int i = 0; i < 8; i++) begin
                            if (mem_be[i]) dev_mem[{mem_addr[7:3], 3'(i)}] = mem_wdata[8*i +: 8];
                        end
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: checks bus fields at the ack and pops the scoreboard on pronto/erro.
    initial begin
        int   reqc;
        exp_t e;
        reqc = 0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                reqc = 0;
            end else begin
                if (mem_req && mem_ack) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_ack: got mem_req with ack expected no access");
                    end else begin
                        check_output("mem_addr", mem_addr, exp_q[0].addr);
                        check_output("mem_be", 64'(mem_be), 64'(exp_q[0].be));
                        check_output("mem_wdata", mem_wdata, exp_q[0].wdata);
                        check_output("mem_we", 64'(mem_we), 64'(exp_q[0].we));
                    end
                end
                if (pronto || erro) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_completion: got pronto=%0d erro=%0d expected none", pronto, erro);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("erro_pulse", 64'(erro), 64'(e.is_err));
                        check_output("pronto_pulse", 64'(pronto), 64'(!e.is_err));
                        check_output("doutDM", doutDM, e.dout);
                        check_output("ocupado_at_end", 64'(ocupado), 64'd0);
                        check_output("req_cycles", 64'(reqc), 64'(e.reqc));
                        done_cnt++;
                    end
                end
                reqc = mem_req ? reqc + 1 : 0;
            end
        end
    end

    initial begin
        bit          we;
        bit          re;
        bit          noack;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] din;
        int          kind;
        n_checks  = 0;
        n_fail    = 0;
        issued    = 0;
        done_cnt  = 0;
        ack_delay = 0;
        no_ack    = 1'b0;
        force_ack = 1'b0;
        last_dout = 64'd0;
        reset     = 1'b1;
        WeDM      = 1'b0;
        ReDM      = 1'b0;
        funct3    = 3'd0;
        doutULA   = 64'd0;
        dinDM     = 64'd0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            dev_mem[i] = ref_mem[i];
        end
        repeat (3) @(negedge clk);
        #1;
        check_output("reset_doutDM", doutDM, 64'd0);
        check_output("reset_ocupado", 64'(ocupado), 64'd0);
        check_output("reset_pronto", 64'(pronto), 64'd0);
        check_output("reset_erro", 64'(erro), 64'd0);
        check_output("reset_mem_req", 64'(mem_req), 64'd0);
        check_output("reset_mem_we", 64'(mem_we), 64'd0);
        check_output("reset_mem_addr", mem_addr, 64'd0);
        check_output("reset_mem_be", 64'(mem_be), 64'd0);
        check_output("reset_mem_wdata", mem_wdata, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed accesses");
        preset_dword(8'h10, 64'h1122_3344_5566_7788);
        apply_stimulus(1'b0, 1'b1, 3'b011, 64'h10, 64'd0, 2, 1'b0);
        ref_mem[8'h13] = 8'h80;
        dev_mem[8'h13] = 8'h80;
        apply_stimulus(1'b0, 1'b1, 3'b000, 64'h13, 64'd0, 0, 1'b0);
        check_output("lb_sign_extend", doutDM, 64'hFFFF_FFFF_FFFF_FF80);
        apply_stimulus(1'b0, 1'b1, 3'b100, 64'h13, 64'd0, 1, 1'b0);
        check_output("lbu_zero_extend", doutDM, 64'h80);
        apply_stimulus(1'b1, 1'b0, 3'b001, 64'h22, 64'hBEEF, 1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 3'b010, 64'h06, 64'd0, 0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 3'b011, 64'h00, 64'd0, 0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 3'b111, 64'h00, 64'd0, 0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 3'b011, 64'h18, 64'd0, 0, 1'b1);

        $display("[TB] random accesses");
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(0, 15);
            we = 1'b0;
            re = 1'b0;
            if (kind < 7) begin
                re = 1'b1;
                f3 = 3'($urandom_range(0, 6));
            end else if (kind < 13) begin
                we = 1'b1;
                f3 = 3'($urandom_range(0, 3));
            end else if (kind == 13) begin
                we = 1'b1;
                re = 1'b1;
                f3 = 3'($urandom_range(0, 7));
            end else if (kind == 14) begin
                re = 1'b1;
                f3 = 3'b111;
            end else begin
                we = 1'b1;
                f3 = 3'($urandom_range(4, 7));
            end
            addr = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) != 0) begin
                case (f3[1:0])
                    2'b01:   addr[0]   = 1'b0;
                    2'b10:   addr[1:0] = 2'b00;
                    2'b11:   addr[2:0] = 3'b000;
                    default: ;
                endcase
            end
            din   = {32'($urandom), 32'($urandom)};
            noack = ($urandom_range(0, 9) == 0);
            apply_stimulus(we, re, f3, addr, din, $urandom_range(0, 3), noack);
        end

        $display("[TB] reset during access");
        preset_dword(8'h40, 64'h0123_4567_89AB_CDEF);
        apply_stimulus(1'b0, 1'b1, 3'b011, 64'h40, 64'd0, 1, 1'b0);
        no_ack  = 1'b1;
        ReDM    = 1'b1;
        funct3  = 3'b011;
        doutULA = 64'h48;
        @(negedge clk);
        ReDM = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        last_dout = 64'd0;
        check_output("rst_mid_mem_req", 64'(mem_req), 64'd0);
        check_output("rst_mid_ocupado", 64'(ocupado), 64'd0);
        check_output("rst_mid_doutDM", doutDM, 64'd0);
        reset     = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        #2;
        force_ack = 1'b0;
        @(negedge clk);
        #1;
        check_output("late_ack_pronto", 64'(pronto), 64'd0);
        check_output("late_ack_erro", 64'(erro), 64'd0);
        check_output("late_ack_doutDM", doutDM, last_dout);
        check_output("late_ack_mem_req", 64'(mem_req), 64'd0);
        check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
